reg_status_file: RTL

Architectural register file with per-register rename tags. It is the receiving end of the ROB's commit-to-register interface and serves the decode stage's operand lookups. Each architectural register holds its committed value and, while an in-flight instruction will overwrite it, the ROB index of that producer. Decode uses the tag to fetch speculative values from the ROB or to wait on the CDB.

---
 rtl/reg_status_file.sv | 115 +++++++++++
 1 files changed

// File: rtl/reg_status_file.sv
// rtl/reg_status_file.sv - architectural register file with per-register rename tags
// Commit writes values and clears matching tags; decode reads bypass same-cycle commits.
module reg_status_file #(
  parameter int ROB_IDX_W = 4,
  parameter int NUM_REGS  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rollback,
  input  logic [4:0]           rs1_addr,
  output logic [31:0]          rs1_data,
  output logic [ROB_IDX_W-1:0] rs1_tag,
  output logic                 rs1_busy,
  input  logic [4:0]           rs2_addr,
  output logic [31:0]          rs2_data,
  output logic [ROB_IDX_W-1:0] rs2_tag,
  output logic                 rs2_busy,
  input  logic                 rename_en,
  input  logic [4:0]           rename_addr,
  input  logic [ROB_IDX_W-1:0] rename_tag,
  input  logic                 commit_we,
  input  logic [4:0]           commit_addr,
  input  logic [31:0]          commit_data,
  input  logic [ROB_IDX_W-1:0] commit_tag,
  output logic [NUM_REGS-1:0]  busy_vec
);

  logic [31:0]          value_q [NUM_REGS];
  logic [31:0]          value_d [NUM_REGS];
  logic [ROB_IDX_W-1:0] tag_q   [NUM_REGS];
  logic [ROB_IDX_W-1:0] tag_d   [NUM_REGS];

  logic commit_ok;
  logic rename_ok;

  assign commit_ok = commit_we && (commit_addr != 5'd0) && (commit_tag != '0);
  assign rename_ok = rename_en && (rename_addr != 5'd0) && (rename_tag != '0) && !rollback;

  // Entry 0 is never written, so it holds the zero it was reset to.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      value_d[i] = value_q[i];
      tag_d[i]   = tag_q[i];
      if (i != 0) begin
        if (commit_ok && (commit_addr == 5'(i))) begin
          value_d[i] = commit_data;
        end
        // A younger rename owns the register over an older producer's tag clear.
        if (rollback) begin
          tag_d[i] = '0;
        end else if (rename_ok && (rename_addr == 5'(i))) begin
          tag_d[i] = rename_tag;
        end else if (commit_ok && (commit_addr == 5'(i)) && (tag_q[i] == commit_tag)) begin
          tag_d[i] = '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        value_q[i] <= '0;
        tag_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        value_q[i] <= value_d[i];
        tag_q[i]   <= tag_d[i];
      end
    end
  end

  // Same-cycle renames are deliberately invisible to reads so rd==rs sees the old producer.
  always_comb begin
    rs1_data = '0;
    rs1_tag  = '0;
    if (rs1_addr != 5'd0) begin
      rs1_data = value_q[rs1_addr];
      rs1_tag  = tag_q[rs1_addr];
      if (commit_ok && (commit_addr == rs1_addr)) begin
        rs1_data = commit_data;
        if (commit_tag == tag_q[rs1_addr]) begin
          rs1_tag = '0;
        end
      end
    end
  end

  always_comb begin
    rs2_data = '0;
    rs2_tag  = '0;
    if (rs2_addr != 5'd0) begin
      rs2_data = value_q[rs2_addr];
      rs2_tag  = tag_q[rs2_addr];
      if (commit_ok && (commit_addr == rs2_addr)) begin
        rs2_data = commit_data;
        if (commit_tag == tag_q[rs2_addr]) begin
          rs2_tag = '0;
        end
      end
    end
  end

  assign rs1_busy = (rs1_tag != '0);
  assign rs2_busy = (rs2_tag != '0);

  always_comb begin
    busy_vec = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      busy_vec[i] = (tag_q[i] != '0);
    end
  end

endmodule
